// File: rtl/rv32i_types.sv
// Shared types for the cacheline adapter: FSM state encoding and burst length.
package rv32i_types;

  localparam int unsigned CACHELINE_BEATS = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BEAT,
    RESP
  } cacheline_adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one DFP cacheline read/write into a 4-beat bmem burst, one transaction at a time.
// Optional: define CACHELINE_ADAPTER_RADDR_CHECK_EN to filter read beats by bmem_raddr.
module cacheline_adapter
  import rv32i_types::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  output logic              raddr_err,
`endif
  input  logic              bmem_rvalid
);

  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  cacheline_adapter_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] rline_q, rline_d;
  logic              beat_ok;
  logic              unused_bits;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  logic raddr_match;
  logic err_q, err_d;

  assign raddr_match = (bmem_raddr[31:OFF_W] == addr_q[31:OFF_W]);
  assign beat_ok     = bmem_rvalid && raddr_match;
  assign unused_bits = ^{dfp_addr[OFF_W-1:0], bmem_raddr[OFF_W-1:0]};

  always_comb begin
    err_d = err_q;
    if (state_q == RD_WAIT && bmem_rvalid && !raddr_match) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign raddr_err = err_q;
`else
  assign beat_ok     = bmem_rvalid;
  assign unused_bits = ^{dfp_addr[OFF_W-1:0], bmem_raddr};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        // Write-back wins when both requests are raised together.
        if (dfp_write) begin
          addr_d  = {dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
          wline_d = dfp_wdata;
          cnt_d   = '0;
          state_d = WR_BEAT;
        end else if (dfp_read) begin
          addr_d  = {dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
          cnt_d   = '0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (beat_ok) begin
          rline_d[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
          end
        end
      end
      WR_BEAT: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // Every output is a decode of registered state only.
  assign dfp_resp   = (state_q == RESP);
  assign dfp_rdata  = rline_q;
  assign bmem_read  = (state_q == RD_REQ);
  assign bmem_write = (state_q == WR_BEAT);
  assign bmem_addr  = addr_q;
  assign bmem_wdata = wline_q[cnt_q*BEAT_W +: BEAT_W];

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: read/write bursts, stalls, priority, reset, gaps.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  logic         raddr_err;
`endif

  int checks = 0;
  int failures = 0;
  logic [255:0] exp_q[$];
  logic [63:0]  beat_q[$];
  logic [255:0] last_line;

  cacheline_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    .raddr_err  (raddr_err),
`endif
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory-side driver for one read; beats start the cycle after command acceptance.
  task automatic do_read(input logic [31:0] a, input int gap, input int bad_at,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3,
                         output int resp_cyc, output int rd_cycles, output logic [31:0] rd_addr,
                         output logic [255:0] line, output int extra);
    logic [63:0] beats[4];
    int bi;
    int wait_n;
    bit streaming;
    bit bad_done;
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    bi = 0; wait_n = 0; streaming = 0; bad_done = 0;
    resp_cyc = -1; rd_cycles = 0; rd_addr = '0; line = '0; extra = 0;
    dfp_addr = a; dfp_read = 1'b1; bmem_ready = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (bmem_read) begin
        if (rd_cycles == 0) rd_addr = bmem_addr;
        rd_cycles++;
      end
      if (dfp_resp) begin
        resp_cyc = c;
        line = dfp_rdata;
        break;
      end
      bmem_rvalid = 1'b0;
      if (streaming && bi < 4) begin
        if (wait_n > 0) begin
          wait_n--;
        end else if (bi == bad_at && !bad_done) begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = a ^ 32'h0000_0100;
          bmem_rdata  = '1;
          bad_done    = 1;
        end else begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = a;
          bmem_rdata  = beats[bi];
          bi++;
          wait_n = gap;
        end
      end
      if (bmem_read && bmem_ready) streaming = 1;
    end
    bmem_rvalid = 1'b0;
    dfp_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (dfp_resp) extra++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({dfp_resp, bmem_read, bmem_write} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000", {dfp_resp, bmem_read, bmem_write});
    end
    checks++;
    if (dfp_rdata !== '0) begin
      failures++;
      $display("FAIL reset_rdata got=%h want=0", dfp_rdata);
    end
    checks++;
    if ({bmem_addr, bmem_wdata} !== 96'h0) begin
      failures++;
      $display("FAIL reset_bmem got=%h/%h want=0/0", bmem_addr, bmem_wdata);
    end
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    checks++;
    if (raddr_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_raddr_err got=%b want=0", raddr_err);
    end
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_fast();
    int rc, nrd, ex;
    logic [31:0] ra;
    logic [255:0] got, want;
    exp_q.push_back({{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}});
    do_read(32'h1234_5678, 0, -1, {4{16'h1111}}, {4{16'h2222}}, {4{16'h3333}}, {4{16'h4444}},
            rc, nrd, ra, got, ex);
    want = exp_q.pop_front();
    checks++;
    if (ra !== 32'h1234_5660) begin
      failures++;
      $display("FAIL rd_fast_addr got=%h want=12345660", ra);
    end
    checks++;
    if (nrd != 1) begin
      failures++;
      $display("FAIL rd_fast_cmd_cycles got=%0d want=1", nrd);
    end
    checks++;
    if (rc != 6) begin
      failures++;
      $display("FAIL rd_fast_latency got=%0d want=6", rc);
    end
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL rd_fast_line got=%h want=%h", got, want);
    end
    checks++;
    if (ex != 0) begin
      failures++;
      $display("FAIL rd_fast_pulse extra=%0d want=0", ex);
    end
    last_line = want;
  endtask

  task automatic test_write_stall();
    logic [255:0] wl, rd_at_resp;
    logic [63:0] exp_b, first_b, prev_data;
    int accepted, resp_c, held_bad, addr_bad, ex;
    bit prev_stall;
    for (int i = 0; i < 32; i++) wl[8*i +: 8] = 8'(i);
    for (int b = 0; b < 4; b++) beat_q.push_back(wl[64*b +: 64]);
    accepted = 0; resp_c = -1; held_bad = 0; addr_bad = 0; ex = 0;
    prev_stall = 0; prev_data = '0; first_b = '0; rd_at_resp = '0;
    dfp_addr = 32'h0000_0040; dfp_wdata = wl; dfp_write = 1'b1; bmem_ready = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (dfp_resp) begin
        resp_c = c;
        rd_at_resp = dfp_rdata;
        break;
      end
      if (bmem_write) begin
        if (bmem_addr !== 32'h0000_0040) addr_bad++;
        if (prev_stall && bmem_wdata !== prev_data) held_bad++;
      end
      bmem_ready = (c % 2 == 1);
      if (bmem_write && bmem_ready) begin
        if (accepted == 0) first_b = bmem_wdata;
        accepted++;
        if (beat_q.size() > 0) begin
          exp_b = beat_q.pop_front();
          checks++;
          if (bmem_wdata !== exp_b) begin
            failures++;
            $display("FAIL wr_beat%0d got=%h want=%h", accepted - 1, bmem_wdata, exp_b);
          end
        end
      end
      prev_stall = bmem_write && !bmem_ready;
      prev_data  = bmem_wdata;
    end
    dfp_write = 1'b0;
    bmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (dfp_resp) ex++;
    end
    checks++;
    if (first_b !== 64'h0706_0504_0302_0100) begin
      failures++;
      $display("FAIL wr_beat0_value got=%h want=0706050403020100", first_b);
    end
    checks++;
    if (accepted != 4) begin
      failures++;
      $display("FAIL wr_accepted got=%0d want=4", accepted);
    end
    checks++;
    if (held_bad != 0 || addr_bad != 0) begin
      failures++;
      $display("FAIL wr_stall_stable got=%0d/%0d want=0/0", held_bad, addr_bad);
    end
    checks++;
    if (resp_c != 8 || ex != 0) begin
      failures++;
      $display("FAIL wr_resp got=cycle%0d/extra%0d want=cycle8/extra0", resp_c, ex);
    end
    checks++;
    if (rd_at_resp !== last_line) begin
      failures++;
      $display("FAIL wr_rdata_kept got=%h want=%h", rd_at_resp, last_line);
    end
  endtask

  task automatic test_simultaneous();
    int resp_c, reads;
    resp_c = -1; reads = 0;
    dfp_addr = 32'h0000_1000; dfp_wdata = {8{32'hCAFE_F00D}};
    dfp_read = 1'b1; dfp_write = 1'b1; bmem_ready = 1'b1;
    tick();
    checks++;
    if ({bmem_write, bmem_read} !== 2'b10) begin
      failures++;
      $display("FAIL both_priority got=%b want=10", {bmem_write, bmem_read});
    end
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (bmem_read) reads++;
      if (dfp_resp) begin
        resp_c = c;
        break;
      end
    end
    dfp_read = 1'b0; dfp_write = 1'b0;
    tick();
    checks++;
    if (reads != 0 || resp_c != 5) begin
      failures++;
      $display("FAIL both_complete got=reads%0d/cycle%0d want=reads0/cycle5", reads, resp_c);
    end
  endtask

  task automatic test_reset_mid_read();
    int resp_seen, rd_seen, rc, nrd, ex;
    logic [31:0] ra;
    logic [255:0] got, want;
    resp_seen = 0; rd_seen = 0;
    dfp_addr = 32'h0000_2000; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick();
    tick();
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_2000; bmem_rdata = {4{16'hDEAD}};
    tick();
    bmem_rdata = {4{16'hBEEF}};
    tick();
    bmem_rvalid = 1'b0;
    rst = 1'b1;
    dfp_read = 1'b0;
    #1;
    checks++;
    if ({dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata, dfp_rdata} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b%b%b/%h/%h/%h want=all0", dfp_resp, bmem_read,
               bmem_write, bmem_addr, bmem_wdata, dfp_rdata);
    end
    bmem_rvalid = 1'b1; bmem_rdata = {4{16'hBAD0}};
    tick();
    rst = 1'b0;
    bmem_rdata = {4{16'hBAD1}};
    tick();
    bmem_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (dfp_resp) resp_seen++;
      if (bmem_read) rd_seen++;
      tick();
    end
    checks++;
    if (resp_seen != 0 || rd_seen != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet got=resp%0d/read%0d want=0/0", resp_seen, rd_seen);
    end
    exp_q.push_back({64'hA4A4_A4A4_A4A4_A4A4, 64'hA3A3_A3A3_A3A3_A3A3,
                     64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1});
    do_read(32'h0000_2000, 0, -1, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA2A2_A2A2_A2A2_A2A2,
            64'hA3A3_A3A3_A3A3_A3A3, 64'hA4A4_A4A4_A4A4_A4A4, rc, nrd, ra, got, ex);
    want = exp_q.pop_front();
    checks++;
    if (got !== want || rc != 6) begin
      failures++;
      $display("FAIL rst_fresh_read got=%h@%0d want=%h@6", got, rc, want);
    end
    last_line = want;
  endtask

  task automatic test_gapped();
    int rc, nrd, ex;
    logic [31:0] ra;
    logic [255:0] got, want;
    exp_q.push_back({64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0});
    do_read(32'hFFFF_FFE4, 3, -1, 64'h0F0F_F0F0_0F0F_F0F0, 64'h5555_AAAA_5555_AAAA,
            64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, rc, nrd, ra, got, ex);
    want = exp_q.pop_front();
    checks++;
    if (rc != 15) begin
      failures++;
      $display("FAIL gap_latency got=%0d want=15", rc);
    end
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL gap_line got=%h want=%h", got, want);
    end
    checks++;
    if (ex != 0 || ra !== 32'hFFFF_FFE0) begin
      failures++;
      $display("FAIL gap_pulse_addr got=extra%0d/%h want=extra0/ffffffe0", ex, ra);
    end
    last_line = want;
  endtask

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  task automatic test_raddr_check();
    int rc, nrd, ex;
    logic [31:0] ra;
    logic [255:0] got, want;
    exp_q.push_back({64'hD4, 64'hD3, 64'hD2, 64'hD1});
    do_read(32'h0000_3000, 0, 2, 64'hD1, 64'hD2, 64'hD3, 64'hD4, rc, nrd, ra, got, ex);
    want = exp_q.pop_front();
    checks++;
    if (got !== want || rc != 7) begin
      failures++;
      $display("FAIL raddr_line got=%h@%0d want=%h@7", got, rc, want);
    end
    checks++;
    if (raddr_err !== 1'b1) begin
      failures++;
      $display("FAIL raddr_err got=%b want=1", raddr_err);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    last_line = '0;
    test_reset();
    test_read_fast();
    test_write_stall();
    test_simultaneous();
    test_reset_mid_read();
    test_gapped();
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    test_raddr_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
